// File: rtl/mpsoc_axi_mem_responder.sv
// AXI3-style memory responder for one packed-valid master port of IP_Top.
// Independent read and write FSMs serve bursts from a 64-bit word array.
module mpsoc_axi_mem_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned DEPTH     = 1024
) (
  input  logic        IP_CLK,
  input  logic        IP_ARESET_N,
  input  logic [32:0] MEM_ARADDR,
  output logic        MEM_ARADDR_ready,
  input  logic [3:0]  MEM_ARLEN,
  input  logic [1:0]  MEM_ARSIZE,
  input  logic [1:0]  MEM_ARBURST,
  output logic [64:0] MEM_RDATA,
  input  logic        MEM_RDATA_ready,
  output logic [1:0]  MEM_RRESP,
  output logic        MEM_RLAST,
  input  logic [32:0] MEM_AWADDR,
  output logic        MEM_AWADDR_ready,
  input  logic [3:0]  MEM_AWLEN,
  input  logic [1:0]  MEM_AWSIZE,
  input  logic [1:0]  MEM_AWBURST,
  input  logic [64:0] MEM_WDATA,
  output logic        MEM_WDATA_ready,
  input  logic [7:0]  MEM_WSTRB,
  input  logic        MEM_WLAST,
  output logic [2:0]  MEM_BRESP,
  input  logic        MEM_BRESP_ready
);

  localparam int unsigned IdxW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] SpanBytes = 33'(DEPTH) * 33'd8;

  localparam logic [0:0] RIdle = 1'b0;
  localparam logic [0:0] RData = 1'b1;
  localparam logic [1:0] WIdle = 2'd0;
  localparam logic [1:0] WData = 2'd1;
  localparam logic [1:0] WResp = 2'd2;

  // Offset is computed modulo 2^32 so addresses below the base land out of range.
  function automatic logic in_range(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    return {1'b0, off} < SpanBytes;
  endfunction

  function automatic logic [IdxW-1:0] word_idx(input logic [31:0] addr);
    return IdxW'((addr - BASE_ADDR) >> 3);
  endfunction

  logic [63:0] mem_q [DEPTH];

  logic unused_size;
  assign unused_size = ^{MEM_ARSIZE, MEM_AWSIZE};

  // Read side
  logic [0:0]  r_state_q, r_state_d;
  logic [31:0] r_addr_q, r_addr_d;
  logic        r_fixed_q, r_fixed_d;
  logic [4:0]  r_left_q, r_left_d;
  logic [63:0] r_data_q, r_data_d;
  logic [1:0]  r_resp_q, r_resp_d;
  logic        r_valid_q, ar_ready_q;
  logic        ar_fire, r_fire, r_fetch;
  logic        rd_in_range;
  logic [IdxW-1:0] rd_idx;
  logic [63:0] rd_word;

  // Write side
  logic [1:0]  w_state_q, w_state_d;
  logic [31:0] w_addr_q, w_addr_d;
  logic        w_fixed_q, w_fixed_d;
  logic [4:0]  w_left_q, w_left_d;
  logic        w_err_q, w_err_d;
  logic [1:0]  b_resp_q, b_resp_d;
  logic        aw_ready_q, w_ready_q, b_valid_q;
  logic        aw_fire, w_fire, b_fire;
  logic        w_in_range, w_commit, w_beat_err;
  logic [IdxW-1:0] w_idx;

  assign ar_fire = ar_ready_q & MEM_ARADDR[32];
  assign r_fire  = r_valid_q & MEM_RDATA_ready;

  always_comb begin
    r_state_d = r_state_q;
    r_addr_d  = r_addr_q;
    r_fixed_d = r_fixed_q;
    r_left_d  = r_left_q;
    r_fetch   = 1'b0;
    case (r_state_q)
      RIdle: begin
        if (ar_fire) begin
          r_state_d = RData;
          r_addr_d  = MEM_ARADDR[31:0];
          r_fixed_d = (MEM_ARBURST == 2'd0);
          r_left_d  = {1'b0, MEM_ARLEN} + 5'd1;
          r_fetch   = 1'b1;
        end
      end
      RData: begin
        if (r_fire) begin
          if (r_left_q == 5'd1) begin
            r_state_d = RIdle;
          end else begin
            r_addr_d = r_fixed_q ? r_addr_q : r_addr_q + 32'd8;
            r_left_d = r_left_q - 5'd1;
            r_fetch  = 1'b1;
          end
        end
      end
      default: r_state_d = RIdle;
    endcase
  end

  assign rd_in_range = in_range(r_addr_d);
  assign rd_idx      = word_idx(r_addr_d);

  // A beat fetched on the same edge as a write to that word sees the new bytes.
  always_comb begin
    rd_word = mem_q[rd_idx];
    if (w_commit && (w_idx == rd_idx)) begin
      for (int i = 0; i < 8; i++) begin
        if (MEM_WSTRB[i]) rd_word[8*i +: 8] = MEM_WDATA[8*i +: 8];
      end
    end
  end

  always_comb begin
    r_data_d = r_data_q;
    r_resp_d = r_resp_q;
    if (r_fetch) begin
      r_data_d = rd_in_range ? rd_word : 64'd0;
      r_resp_d = rd_in_range ? 2'd0 : 2'd2;
    end
  end

  assign aw_fire    = aw_ready_q & MEM_AWADDR[32];
  assign w_fire     = w_ready_q & MEM_WDATA[64];
  assign b_fire     = b_valid_q & MEM_BRESP_ready;
  assign w_in_range = in_range(w_addr_q);
  assign w_idx      = word_idx(w_addr_q);
  assign w_commit   = w_fire & w_in_range;
  // WLAST only feeds the error flag; the beat count alone ends the burst.
  assign w_beat_err = ~w_in_range | (MEM_WLAST != (w_left_q == 5'd1));

  always_comb begin
    w_state_d = w_state_q;
    w_addr_d  = w_addr_q;
    w_fixed_d = w_fixed_q;
    w_left_d  = w_left_q;
    w_err_d   = w_err_q;
    b_resp_d  = b_resp_q;
    case (w_state_q)
      WIdle: begin
        if (aw_fire) begin
          w_state_d = WData;
          w_addr_d  = MEM_AWADDR[31:0];
          w_fixed_d = (MEM_AWBURST == 2'd0);
          w_left_d  = {1'b0, MEM_AWLEN} + 5'd1;
          w_err_d   = 1'b0;
        end
      end
      WData: begin
        if (w_fire) begin
          w_err_d = w_err_q | w_beat_err;
          if (w_left_q == 5'd1) begin
            w_state_d = WResp;
            b_resp_d  = (w_err_q | w_beat_err) ? 2'd2 : 2'd0;
          end else begin
            w_addr_d = w_fixed_q ? w_addr_q : w_addr_q + 32'd8;
            w_left_d = w_left_q - 5'd1;
          end
        end
      end
      WResp: begin
        if (b_fire) w_state_d = WIdle;
      end
      default: w_state_d = WIdle;
    endcase
  end

  always_ff @(posedge IP_CLK or negedge IP_ARESET_N) begin
    if (!IP_ARESET_N) begin
      r_state_q  <= RIdle;
      r_addr_q   <= '0;
      r_fixed_q  <= 1'b0;
      r_left_q   <= '0;
      r_data_q   <= '0;
      r_resp_q   <= '0;
      r_valid_q  <= 1'b0;
      ar_ready_q <= 1'b0;
      w_state_q  <= WIdle;
      w_addr_q   <= '0;
      w_fixed_q  <= 1'b0;
      w_left_q   <= '0;
      w_err_q    <= 1'b0;
      b_resp_q   <= '0;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      b_valid_q  <= 1'b0;
    end else begin
      r_state_q  <= r_state_d;
      r_addr_q   <= r_addr_d;
      r_fixed_q  <= r_fixed_d;
      r_left_q   <= r_left_d;
      r_data_q   <= r_data_d;
      r_resp_q   <= r_resp_d;
      r_valid_q  <= (r_state_d == RData);
      ar_ready_q <= (r_state_d == RIdle);
      w_state_q  <= w_state_d;
      w_addr_q   <= w_addr_d;
      w_fixed_q  <= w_fixed_d;
      w_left_q   <= w_left_d;
      w_err_q    <= w_err_d;
      b_resp_q   <= b_resp_d;
      aw_ready_q <= (w_state_d == WIdle);
      w_ready_q  <= (w_state_d == WData);
      b_valid_q  <= (w_state_d == WResp);
    end
  end

  always_ff @(posedge IP_CLK) begin
    if (w_commit) begin
      for (int i = 0; i < 8; i++) begin
        if (MEM_WSTRB[i]) mem_q[w_idx][8*i +: 8] <= MEM_WDATA[8*i +: 8];
      end
    end
  end

  assign MEM_ARADDR_ready = ar_ready_q;
  assign MEM_RDATA        = {r_valid_q, r_data_q};
  assign MEM_RRESP        = r_resp_q;
  assign MEM_RLAST        = r_valid_q & (r_left_q == 5'd1);
  assign MEM_AWADDR_ready = aw_ready_q;
  assign MEM_WDATA_ready  = w_ready_q;
  assign MEM_BRESP        = {b_valid_q, b_resp_q};

endmodule

// File: tb/tb_mpsoc_axi_mem_responder.sv
// Bench for mpsoc_axi_mem_responder: vector table, reset sequences and random bursts
// checked against a word-array model of the memory.
module tb_mpsoc_axi_mem_responder;

  localparam logic [31:0] Base    = 32'h3000_0000;
  localparam int unsigned Depth   = 1024;
  localparam logic [31:0] EndAddr = Base + 32'(Depth * 8);
  localparam logic [31:0] Win     = Base + 32'h1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [32:0] MEM_ARADDR = '0;
  logic        MEM_ARADDR_ready;
  logic [3:0]  MEM_ARLEN = '0;
  logic [1:0]  MEM_ARSIZE = '0;
  logic [1:0]  MEM_ARBURST = '0;
  logic [64:0] MEM_RDATA;
  logic        MEM_RDATA_ready = 1'b0;
  logic [1:0]  MEM_RRESP;
  logic        MEM_RLAST;
  logic [32:0] MEM_AWADDR = '0;
  logic        MEM_AWADDR_ready;
  logic [3:0]  MEM_AWLEN = '0;
  logic [1:0]  MEM_AWSIZE = '0;
  logic [1:0]  MEM_AWBURST = '0;
  logic [64:0] MEM_WDATA = '0;
  logic        MEM_WDATA_ready;
  logic [7:0]  MEM_WSTRB = '0;
  logic        MEM_WLAST = 1'b0;
  logic [2:0]  MEM_BRESP;
  logic        MEM_BRESP_ready = 1'b0;

  int total = 0;
  int bad = 0;
  logic [63:0] mdl [int];

  always #5 clk = ~clk;

  mpsoc_axi_mem_responder #(
    .BASE_ADDR(Base),
    .DEPTH    (Depth)
  ) dut (
    .IP_CLK          (clk),
    .IP_ARESET_N     (rst_n),
    .MEM_ARADDR      (MEM_ARADDR),
    .MEM_ARADDR_ready(MEM_ARADDR_ready),
    .MEM_ARLEN       (MEM_ARLEN),
    .MEM_ARSIZE      (MEM_ARSIZE),
    .MEM_ARBURST     (MEM_ARBURST),
    .MEM_RDATA       (MEM_RDATA),
    .MEM_RDATA_ready (MEM_RDATA_ready),
    .MEM_RRESP       (MEM_RRESP),
    .MEM_RLAST       (MEM_RLAST),
    .MEM_AWADDR      (MEM_AWADDR),
    .MEM_AWADDR_ready(MEM_AWADDR_ready),
    .MEM_AWLEN       (MEM_AWLEN),
    .MEM_AWSIZE      (MEM_AWSIZE),
    .MEM_AWBURST     (MEM_AWBURST),
    .MEM_WDATA       (MEM_WDATA),
    .MEM_WDATA_ready (MEM_WDATA_ready),
    .MEM_WSTRB       (MEM_WSTRB),
    .MEM_WLAST       (MEM_WLAST),
    .MEM_BRESP       (MEM_BRESP),
    .MEM_BRESP_ready (MEM_BRESP_ready)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    int          len;
    bit          fixed;
    logic [63:0] data0;
    logic [7:0]  strb;
    int          wlast_at;
    int          stall;
    logic [63:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out, expected handshake", name);
  endtask

  function automatic bit m_in_range(input logic [31:0] a);
    return (a >= Base) && (a < EndAddr);
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((a - Base) >> 3);
  endfunction

  function automatic bit stall_take(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return ((cyc % 4) == 0) || ((cyc % 4) == 3);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic send_addr(input bit wr, input logic [31:0] addr, input int len, input bit fixed,
                           output bit ok);
    int n;
    @(negedge clk);
    if (wr) begin
      MEM_AWADDR  = {1'b1, addr};
      MEM_AWLEN   = 4'(len);
      MEM_AWBURST = fixed ? 2'd0 : 2'd1;
      MEM_AWSIZE  = 2'd3;
    end else begin
      MEM_ARADDR  = {1'b1, addr};
      MEM_ARLEN   = 4'(len);
      MEM_ARBURST = fixed ? 2'd0 : 2'd1;
      MEM_ARSIZE  = 2'd3;
    end
    n = 0;
    while (!(wr ? MEM_AWADDR_ready : MEM_ARADDR_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = (n < 50);
    if (!ok) timeout(wr ? "aw_handshake" : "ar_handshake");
    @(posedge clk);
    #1;
    MEM_AWADDR[32] = 1'b0;
    MEM_ARADDR[32] = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input int len, input bit fixed, input int stall,
                         output logic [63:0] last_data, output logic [1:0] last_resp);
    bit ok, held, take;
    int beat, cyc;
    logic [66:0] saved;
    logic [31:0] a;
    logic [1:0] er;
    last_data = '0;
    last_resp = 2'd3;
    saved = '0;
    send_addr(1'b0, addr, len, fixed, ok);
    if (!ok) return;
    beat = 0;
    cyc = 0;
    held = 1'b0;
    while (beat <= len && cyc < 300) begin
      @(negedge clk);
      if (cyc == 0) check("ar_ready_low_in_burst", 128'(MEM_ARADDR_ready), 128'(0));
      if (MEM_RDATA[64]) begin
        if (held) begin
          check("r_hold_while_stalled", 128'({MEM_RLAST, MEM_RRESP, MEM_RDATA[63:0]}),
                128'(saved));
        end else begin
          a = fixed ? addr : addr + 32'(8 * beat);
          er = m_in_range(a) ? 2'd0 : 2'd2;
          if (!m_in_range(a)) check("r_data_oor", 128'(MEM_RDATA[63:0]), 128'(0));
          else if (mdl.exists(m_idx(a)))
            check("r_data", 128'(MEM_RDATA[63:0]), 128'(mdl[m_idx(a)]));
          check("r_resp", 128'(MEM_RRESP), 128'(er));
          check("r_last", 128'(MEM_RLAST), 128'(beat == len));
        end
        take = stall_take(stall, cyc);
        MEM_RDATA_ready = take;
        if (take) begin
          last_data = MEM_RDATA[63:0];
          last_resp = MEM_RRESP;
          beat++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          saved = {MEM_RLAST, MEM_RRESP, MEM_RDATA[63:0]};
        end
      end else begin
        MEM_RDATA_ready = 1'b0;
        check("r_valid_in_burst", 128'(MEM_RDATA[64]), 128'(1));
      end
      cyc++;
    end
    if (beat <= len) timeout("r_beats");
    @(negedge clk);
    MEM_RDATA_ready = 1'b0;
    check("r_valid_after_last", 128'(MEM_RDATA[64]), 128'(0));
    check("ar_ready_after_last", 128'(MEM_ARADDR_ready), 128'(1));
  endtask

  task automatic do_write(input logic [31:0] addr, input int len, input bit fixed,
                          input logic [63:0] data0, input logic [7:0] strb, input int wlast_at,
                          input bit gaps, output logic [1:0] resp);
    bit ok, err;
    int n, idx;
    logic [31:0] a;
    logic [63:0] d, w;
    resp = 2'd3;
    send_addr(1'b1, addr, len, fixed, ok);
    if (!ok) return;
    err = 1'b0;
    for (int b = 0; b <= len; b++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      @(negedge clk);
      d = data0 * 64'(b + 1);
      MEM_WDATA = {1'b1, d};
      MEM_WSTRB = strb;
      MEM_WLAST = (b == wlast_at);
      n = 0;
      while (!MEM_WDATA_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (n >= 50) begin
        timeout("w_handshake");
        MEM_WDATA[64] = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      MEM_WDATA[64] = 1'b0;
      MEM_WLAST = 1'b0;
      a = fixed ? addr : addr + 32'(8 * b);
      if ((b == wlast_at) != (b == len)) err = 1'b1;
      if (!m_in_range(a)) begin
        err = 1'b1;
      end else begin
        idx = m_idx(a);
        w = mdl.exists(idx) ? mdl[idx] : 64'd0;
        for (int k = 0; k < 8; k++) if (strb[k]) w[8*k +: 8] = d[8*k +: 8];
        mdl[idx] = w;
      end
    end
    @(negedge clk);
    check("b_valid_after_last", 128'(MEM_BRESP[2]), 128'(1));
    check("w_ready_after_last", 128'(MEM_WDATA_ready), 128'(0));
    n = 0;
    while (!MEM_BRESP[2] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      timeout("b_valid");
      return;
    end
    if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    check("b_resp", 128'(MEM_BRESP[1:0]), 128'(err ? 2'd2 : 2'd0));
    resp = MEM_BRESP[1:0];
    MEM_BRESP_ready = 1'b1;
    @(posedge clk);
    #1;
    MEM_BRESP_ready = 1'b0;
    @(negedge clk);
    check("aw_ready_after_b", 128'(MEM_AWADDR_ready), 128'(1));
    check("b_valid_cleared", 128'(MEM_BRESP[2]), 128'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    logic [63:0] ld;
    logic [1:0]  lr;
    int len, start;
    bit fixed;

    //            wr addr            len fx data0                  strb   wl  st exp_data                exp_resp
    vecs[0]  = '{1, Base,            3, 0, 64'h11,                8'hFF, 3,  0, 64'h0,                 2'd0};
    vecs[1]  = '{0, Base,            3, 0, 64'h0,                 8'h00, 0,  0, 64'h44,                2'd0};
    vecs[2]  = '{1, Base + 32'h40,   0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 0, 64'h0,                 2'd0};
    vecs[3]  = '{1, Base + 32'h40,   0, 0, 64'h0,                 8'h0F, 0,  0, 64'h0,                 2'd0};
    vecs[4]  = '{0, Base + 32'h40,   0, 0, 64'h0,                 8'h00, 0,  0, 64'hFFFF_FFFF_0000_0000, 2'd0};
    vecs[5]  = '{0, Base,            3, 0, 64'h0,                 8'h00, 0,  1, 64'h44,                2'd0};
    vecs[6]  = '{1, EndAddr - 32'd8, 0, 0, 64'h5A,                8'hFF, 0,  0, 64'h0,                 2'd0};
    vecs[7]  = '{0, EndAddr - 32'd8, 1, 0, 64'h0,                 8'h00, 0,  0, 64'h0,                 2'd2};
    vecs[8]  = '{1, Base + 32'h80,   3, 0, 64'h1,                 8'hFF, 1,  0, 64'h0,                 2'd2};
    vecs[9]  = '{0, Base + 32'h80,   3, 0, 64'h0,                 8'h00, 0,  0, 64'h4,                 2'd0};
    vecs[10] = '{1, Base + 32'h100,  2, 1, 64'h7,                 8'hFF, 2,  0, 64'h0,                 2'd0};
    vecs[11] = '{0, Base + 32'h100,  0, 0, 64'h0,                 8'h00, 0,  0, 64'h15,                2'd0};
    vecs[12] = '{1, Base - 32'd8,    1, 0, 64'h3,                 8'hFF, 1,  0, 64'h0,                 2'd2};
    vecs[13] = '{0, Base,            0, 0, 64'h0,                 8'h00, 0,  0, 64'h6,                 2'd0};
    vecs[14] = '{1, Base + 32'h200,  1, 0, 64'h9,                 8'hFF, -1, 0, 64'h0,                 2'd2};
    vecs[15] = '{0, Base - 32'd8,    1, 1, 64'h0,                 8'h00, 0,  0, 64'h0,                 2'd2};
    vecs[16] = '{0, Base + 32'h200,  1, 0, 64'h0,                 8'h00, 0,  2, 64'h12,                2'd0};

    repeat (3) @(negedge clk);
    check("outputs_in_reset",
          128'({MEM_ARADDR_ready, MEM_RDATA, MEM_RRESP, MEM_RLAST, MEM_AWADDR_ready,
                MEM_WDATA_ready, MEM_BRESP}), 128'(0));
    rst_n = 1'b1;
    #1;
    check("ready_before_first_edge", 128'({MEM_ARADDR_ready, MEM_AWADDR_ready}), 128'(0));
    @(negedge clk);
    check("ready_after_first_edge", 128'({MEM_ARADDR_ready, MEM_AWADDR_ready}), 128'(2'b11));
    check("no_spurious_valid", 128'({MEM_RDATA[64], MEM_WDATA_ready, MEM_BRESP[2]}), 128'(0));

    for (int i = 0; i < 17; i++) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].addr, vecs[i].len, vecs[i].fixed, vecs[i].data0, vecs[i].strb,
                 vecs[i].wlast_at, 1'b0, lr);
        check($sformatf("vec%0d_bresp", i), 128'(lr), 128'(vecs[i].exp_resp));
      end else begin
        do_read(vecs[i].addr, vecs[i].len, vecs[i].fixed, vecs[i].stall, ld, lr);
        check($sformatf("vec%0d_last_data", i), 128'(ld), 128'(vecs[i].exp_data));
        check($sformatf("vec%0d_last_resp", i), 128'(lr), 128'(vecs[i].exp_resp));
      end
    end

    // Reset in the middle of a read burst, after two beats have been accepted.
    @(negedge clk);
    MEM_ARADDR  = {1'b1, Base};
    MEM_ARLEN   = 4'd3;
    MEM_ARBURST = 2'd1;
    @(posedge clk);
    #1;
    MEM_ARADDR[32]  = 1'b0;
    MEM_RDATA_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rvalid_on_async_reset", 128'({MEM_RDATA[64], MEM_RLAST}), 128'(0));
    check("ar_ready_on_async_reset", 128'(MEM_ARADDR_ready), 128'(0));
    MEM_RDATA_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_read(Base, 3, 1'b0, 0, ld, lr);
    check("read_after_reset_last", 128'(ld), 128'(64'h44));

    // Random bursts within a prefilled window.
    do_write(Win, 15, 1'b0, 64'h0101_0101_0101_0101, 8'hFF, 15, 1'b0, lr);
    do_write(Win + 32'h80, 15, 1'b0, 64'h0303_0303_0303_0303, 8'hFF, 15, 1'b0, lr);
    for (int it = 0; it < 40; it++) begin
      len = $urandom_range(0, 7);
      start = $urandom_range(0, 31 - len);
      fixed = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) begin
        do_write(Win + 32'(8 * start), len, fixed, {$urandom, $urandom}, 8'($urandom),
                 ($urandom_range(0, 4) == 0) ? $urandom_range(0, len) : len, 1'b1, lr);
      end else begin
        do_read(Win + 32'(8 * start), len, fixed, 2, ld, lr);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
